// File: rtl/bill_shift_scaler_if.sv
// Handshake and data bundle for the bill amount power-of-two scaler.
// The master drives requests and the output enable; the slave returns result and status.
interface bill_shift_scaler_if #(
    parameter int WIDTH = 13,
    parameter int SHW   = 4
);
    logic             start;
    logic             dir;
    logic [SHW-1:0]   amt;
    logic             rnd;
    logic [WIDTH-1:0] din;
    logic             ed;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, dir, amt, rnd, din, ed,
        input  dout, busy, done, ovf
    );

    modport slave (
        input  start, dir, amt, rnd, din, ed,
        output dout, busy, done, ovf
    );
endinterface

// File: rtl/bill_shift_scaler.sv
// Sequential power-of-two scaler: one shift per clock, round-half-up on right
// shifts, saturation on left-shift overflow, enable-gated result output.
module bill_shift_scaler #(
    parameter int WIDTH = 13,
    parameter int SHW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    bill_shift_scaler_if.slave  bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;
    logic             r_rnd;
    logic             r_guard;
    logic             r_sticky;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_done;

    logic             w_busy;
    logic [WIDTH-1:0] w_round;

    assign w_busy  = (r_state == S_SHIFT);
    assign w_round = WIDTH'(r_rnd & r_guard);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_rnd    <= 1'b0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work   <= bus.din;
                        r_cnt    <= bus.amt;
                        r_dir    <= bus.dir;
                        r_rnd    <= bus.rnd & ~bus.dir;
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        if (r_dir) begin
                            r_sticky <= r_sticky | r_work[WIDTH-1];
                            r_work   <= r_work << 1;
                        end else begin
                            r_guard  <= r_work[0];
                            r_work   <= r_work >> 1;
                        end
                        r_cnt <= r_cnt - SHW'(1);
                    end else begin
                        // A set guard means at least one right step, so the MSB is clear and the add cannot carry out.
                        if (r_dir) begin
                            r_result <= r_sticky ? '1 : r_work;
                            r_ovf    <= r_sticky;
                        end else begin
                            r_result <= r_work + w_round;
                            r_ovf    <= 1'b0;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dout = bus.ed ? r_result : '0;
    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bill_shift_scaler.sv
// Randomized and directed bench for bill_shift_scaler against an arithmetic reference model.
module tb_bill_shift_scaler;

    localparam int W = 13;
    localparam int S = 4;
    localparam int ALL1 = (1 << W) - 1;

    logic clk;
    logic rst;

    bill_shift_scaler_if #(.WIDTH(W), .SHW(S)) bus();

    bill_shift_scaler #(.WIDTH(W), .SHW(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: cycles remaining, pending and visible result.
    int m_rem  = 0;
    int m_res  = 0;
    bit m_ovf  = 1'b0;
    bit m_done = 1'b0;
    int p_res  = 0;
    bit p_ovf  = 1'b0;

    function automatic void scale(input int d, input bit dr, input int a, input bit r,
                                  output int res, output bit ov);
        int full;
        int guard;
        if (dr) begin
            full = d << a;
            ov   = (full >> W) != 0;
            res  = ov ? ALL1 : (full & ALL1);
        end else begin
            guard = (a == 0) ? 0 : ((d >> (a - 1)) & 1);
            res   = (d >> a) + (r ? guard : 0);
            ov    = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_res = 0; m_ovf = 1'b0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
            if (m_rem == 0) begin
                m_res = p_res;
                m_ovf = p_ovf;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_rem = int'(bus.amt) + 1;
                scale(int'(bus.din), bus.dir, int'(bus.amt), bus.rnd, p_res, p_ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(bus.busy), (m_rem > 0) ? 1 : 0);
            check("done", int'(bus.done), int'(m_done));
            check("ovf",  int'(bus.ovf),  int'(m_ovf));
            check("dout", int'(bus.dout), bus.ed ? m_res : 0);
        end
    end

    task automatic drive(input int d, input bit dr, input int a, input bit r);
        bus.din = W'(d);
        bus.dir = dr;
        bus.amt = S'(a);
        bus.rnd = r;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, int'(seen), 1);
    endtask

    task automatic run_op(input string name, input int d, input bit dr, input int a, input bit r,
                          input int exp_dout, input int exp_ovf);
        @(posedge clk); #1;
        drive(d, dr, a, r);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive(0, 1'b0, 0, 1'b0);
        wait_done(name);
        check({name, "_dout"}, int'(bus.dout), exp_dout);
        check({name, "_ovf"},  int'(bus.ovf),  exp_ovf);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ed = 1'b1;
        drive(0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_dout", int'(bus.dout), 0);
        check("reset_busy", int'(bus.busy), 0);

        run_op("div4",     1000, 1'b0, 2,  1'b0, 250,  0);
        run_op("rnd_up",   1002, 1'b0, 2,  1'b1, 251,  0);
        run_op("rnd_off",  1002, 1'b0, 2,  1'b0, 250,  0);
        run_op("mul8",     1000, 1'b1, 3,  1'b0, 8000, 0);
        run_op("sat",      5000, 1'b1, 1,  1'b0, 8191, 1);
        run_op("amt0",     4321, 1'b0, 0,  1'b0, 4321, 0);
        run_op("amt15",    8191, 1'b0, 15, 1'b1, 0,    0);
        run_op("big_left", 1,    1'b1, 15, 1'b0, 8191, 1);

        // Start pulsed while busy must be ignored.
        @(posedge clk); #1;
        drive(1000, 1'b0, 2, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        drive(7, 1'b1, 9, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("busy_ign");
        check("busy_ign_dout", int'(bus.dout), 250);
        repeat (12) @(negedge clk);

        // Start held high: back-to-back operations.
        @(posedge clk); #1;
        drive(600, 1'b0, 1, 1'b0);
        bus.start = 1'b1;
        repeat (8) @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("held_dout", int'(bus.dout), 300);

        // Output gate.
        #1 bus.ed = 1'b0;
        @(negedge clk);
        check("gate_off", int'(bus.dout), 0);
        #1 bus.ed = 1'b1;
        #1 check("gate_on", int'(bus.dout), 300);

        // Reset mid-shift aborts the operation.
        @(posedge clk); #1;
        drive(4000, 1'b0, 10, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_dout", int'(bus.dout), 0);
        repeat (15) @(negedge clk);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            drive(int'($urandom_range(0, ALL1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            bus.start = ($urandom_range(0, 2) == 0);
            bus.ed    = ($urandom_range(0, 7) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
